// File: rtl/video_blitter.sv
// Rectangle-fill engine for the 320x200 4bpp framebuffer held in video RAM.
// The CPU programs it over the I/O port bus. Edge nibbles are written with read-modify-write.
module video_blitter #(
    parameter logic [15:0] BASE_ADDR  = 16'h0100,
    parameter int          SCREEN_W   = 320,
    parameter int          SCREEN_H   = 200,
    parameter int          LINE_BYTES = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] port_add,
    input  logic [7:0]  port_wdata,
    input  logic        port_we,
    output logic [7:0]  port_rdata,
    output logic [14:0] vid_add,
    output logic [7:0]  vid_wdata,
    input  logic [7:0]  vid_rdata,
    output logic        vid_we,
    output logic        busy
);
    localparam logic [8:0]  SCR_W = 9'(SCREEN_W);
    localparam logic [7:0]  SCR_H = 8'(SCREEN_H);
    localparam logic [14:0] LB    = 15'(LINE_BYTES);

    typedef enum logic [2:0] {IDLE, STEP, RD, RDW, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  x_q, x_d, w_q, w_d, cx_q, cx_d, xend_q, xend_d;
    logic [7:0]  y_q, y_d, h_q, h_d, rows_q, rows_d, rd_q, rd_d;
    logic [3:0]  color_q, color_d;
    logic [14:0] base_q, base_d;
    logic        done_q, done_d;

    logic [15:0] off;
    logic        in_win, start, degenerate;
    logic [8:0]  rem_w, weff, xend_new, nxt;
    logic [7:0]  rem_h, heff;
    logic [14:0] pix_addr;

    // Constant multiply by LINE_BYTES as a sum of shifts; only used once per START.
    function automatic logic [14:0] row_base_of(input logic [7:0] y);
        logic [14:0] acc;
        acc = '0;
        for (int i = 0; i < 15; i++)
            if (LB[i]) acc = acc + (15'(y) << i);
        return acc;
    endfunction

    // A byte whose two pixels are both inside the span is written directly.
    function automatic state_t first_access(input logic [8:0] cx, input logic [8:0] xend);
        return (!cx[0] && ({1'b0, cx} + 10'd1 <= {1'b0, xend})) ? STEP : RD;
    endfunction

    assign off        = port_add - BASE_ADDR;
    assign in_win     = (off < 16'd8);
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign start      = port_we && in_win && (off[2:0] == 3'd7) && !busy;
    assign degenerate = (w_q == 9'd0) || (h_q == 8'd0) || (x_q >= SCR_W) || (y_q >= SCR_H);
    assign rem_w      = SCR_W - x_q;
    assign weff       = (w_q < rem_w) ? w_q : rem_w;
    assign rem_h      = SCR_H - y_q;
    assign heff       = (h_q < rem_h) ? h_q : rem_h;
    assign xend_new   = x_q + weff - 9'd1;
    assign nxt        = cx_q + ((state_q == STEP) ? 9'd2 : 9'd1);
    assign pix_addr   = base_q + {6'd0, cx_q[8:1]};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        cx_d    = cx_q;
        xend_d  = xend_q;
        rows_d  = rows_q;
        base_d  = base_q;
        rd_d    = rd_q;
        done_d  = done_q;

        if (port_we && in_win && !busy) begin
            case (off[2:0])
                3'd0:    x_d = {x_q[8], port_wdata};
                3'd1:    x_d = {port_wdata[0], x_q[7:0]};
                3'd2:    y_d = port_wdata;
                3'd3:    w_d = {w_q[8], port_wdata};
                3'd4:    w_d = {port_wdata[0], w_q[7:0]};
                3'd5:    h_d = port_wdata;
                3'd6:    color_d = port_wdata[3:0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    done_d = degenerate;
                    if (!degenerate) begin
                        cx_d    = x_q;
                        xend_d  = xend_new;
                        rows_d  = heff;
                        base_d  = row_base_of(y_q);
                        state_d = first_access(x_q, xend_new);
                    end
                end
            end
            STEP, WR: begin
                if (nxt > xend_q) begin
                    if (rows_q == 8'd1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        rows_d  = rows_q - 8'd1;
                        base_d  = base_q + LB;
                        cx_d    = x_q;
                        state_d = first_access(x_q, xend_q);
                    end
                end else begin
                    cx_d    = nxt;
                    state_d = first_access(nxt, xend_q);
                end
            end
            RD:      state_d = RDW;
            RDW: begin
                rd_d    = vid_rdata;
                state_d = WR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vid_we    = 1'b0;
        vid_add   = '0;
        vid_wdata = '0;
        case (state_q)
            STEP: begin
                vid_we    = 1'b1;
                vid_add   = pix_addr;
                vid_wdata = {color_q, color_q};
            end
            RD, RDW: vid_add = pix_addr;
            WR: begin
                vid_we    = 1'b1;
                vid_add   = pix_addr;
                vid_wdata = cx_q[0] ? {rd_q[7:4], color_q} : {color_q, rd_q[3:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        port_rdata = 8'h00;
        if (in_win) begin
            case (off[2:0])
                3'd0:    port_rdata = x_q[7:0];
                3'd1:    port_rdata = {7'd0, x_q[8]};
                3'd2:    port_rdata = y_q;
                3'd3:    port_rdata = w_q[7:0];
                3'd4:    port_rdata = {7'd0, w_q[8]};
                3'd5:    port_rdata = h_q;
                3'd6:    port_rdata = {4'd0, color_q};
                default: port_rdata = {6'd0, done_q, busy};
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            cx_q    <= '0;
            xend_q  <= '0;
            rows_q  <= '0;
            base_q  <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            cx_q    <= cx_d;
            xend_q  <= xend_d;
            rows_q  <= rows_d;
            base_q  <= base_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_video_blitter.sv
// Directed bench for video_blitter: a behavioural video RAM with one-cycle read latency
// plus a negedge write logger; expected values are hand-computed.
module tb_video_blitter;
    localparam logic [15:0] BASE = 16'h0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] port_add;
    logic [7:0]  port_wdata;
    logic        port_we;
    logic [7:0]  port_rdata;
    logic [14:0] vid_add;
    logic [7:0]  vid_wdata;
    logic [7:0]  vid_rdata;
    logic        vid_we;
    logic        busy;

    video_blitter #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .port_add(port_add), .port_wdata(port_wdata), .port_we(port_we), .port_rdata(port_rdata),
        .vid_add(vid_add), .vid_wdata(vid_wdata), .vid_rdata(vid_rdata), .vid_we(vid_we),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:32767];
    always @(posedge clk) begin
        vid_rdata <= ram[vid_add];
        if (vid_we) ram[vid_add] <= vid_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_add[$];
    int wr_dat[$];
    int wr_cyc[$];
    int busy_cnt = 0;
    int addr_bad = 0;
    always @(negedge clk) begin
        if (vid_we) begin
            wr_add.push_back(int'(vid_add));
            wr_dat.push_back(int'(vid_wdata));
            wr_cyc.push_back(cyc);
            if (vid_add > 15'd31999) addr_bad++;
        end
        if (busy) busy_cnt++;
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         t_last, t0;
    logic [7:0] first_status, rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic port_write(input logic [2:0] o, input logic [7:0] d);
        @(posedge clk);
        #1;
        port_add   = BASE + {13'd0, o};
        port_wdata = d;
        port_we    = 1'b1;
        t_last     = cyc;
        @(posedge clk);
        #1;
        port_we  = 1'b0;
        port_add = 16'h0000;
    endtask

    task automatic port_read(input logic [15:0] a, output logic [7:0] d);
        port_add = a;
        #1;
        d = port_rdata;
    endtask

    task automatic set_rect(input int x, input int y, input int w, input int h, input logic [7:0] c);
        port_write(3'd0, x[7:0]);
        port_write(3'd1, {7'd0, x[8]});
        port_write(3'd2, y[7:0]);
        port_write(3'd3, w[7:0]);
        port_write(3'd4, {7'd0, w[8]});
        port_write(3'd5, h[7:0]);
        port_write(3'd6, c);
    endtask

    task automatic start_fill();
        wr_add.delete();
        wr_dat.delete();
        wr_cyc.delete();
        busy_cnt = 0;
        addr_bad = 0;
        port_write(3'd7, 8'h00);
        t0 = t_last;
    endtask

    task automatic wait_fill();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i == 0) port_read(BASE + 16'd7, first_status);
            if (!busy) break;
        end
        check("fill_terminates", 32'(busy), 32'd0);
    endtask

    task automatic check_wr(input string tag, input int idx, input int a, input int d, input int c);
        if (idx >= wr_add.size()) begin
            check({tag, "_present"}, wr_add.size(), idx + 1);
        end else begin
            check({tag, "_add"}, wr_add[idx], a);
            check({tag, "_data"}, wr_dat[idx], d);
            check({tag, "_cycle"}, wr_cyc[idx], c);
        end
    endtask

    initial begin
        int nd;
        rst        = 1'b1;
        port_add   = 16'h0000;
        port_wdata = 8'h00;
        port_we    = 1'b0;
        for (int i = 0; i < 32768; i++) ram[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_vid_we", 32'(vid_we), 0);
        check("rst_vid_add", 32'(vid_add), 0);
        check("rst_vid_wdata", 32'(vid_wdata), 0);
        port_read(BASE + 16'd7, rd); check("rst_status", 32'(rd), 0);
        port_read(BASE + 16'd0, rd); check("rst_x", 32'(rd), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // register readback, colour masked to 4 bits, window edges read zero
        set_rect(346, 8'h42, 9'h1C3, 8'h99, 8'hFB);
        @(negedge clk);
        port_read(BASE + 16'd0, rd); check("rb_x_lo", 32'(rd), 32'h5A);
        port_read(BASE + 16'd1, rd); check("rb_x_hi", 32'(rd), 32'h01);
        port_read(BASE + 16'd2, rd); check("rb_y", 32'(rd), 32'h42);
        port_read(BASE + 16'd3, rd); check("rb_w_lo", 32'(rd), 32'hC3);
        port_read(BASE + 16'd4, rd); check("rb_w_hi", 32'(rd), 32'h01);
        port_read(BASE + 16'd5, rd); check("rb_h", 32'(rd), 32'h99);
        port_read(BASE + 16'd6, rd); check("rb_color", 32'(rd), 32'h0B);
        port_read(BASE + 16'd8, rd); check("rb_above_win", 32'(rd), 0);
        port_read(BASE - 16'd1, rd); check("rb_below_win", 32'(rd), 0);

        // full bytes
        set_rect(0, 0, 4, 1, 8'h05);
        start_fill();
        wait_fill();
        check("full_count", wr_add.size(), 2);
        check_wr("full_w0", 0, 0, 32'h55, t0 + 1);
        check_wr("full_w1", 1, 1, 32'h55, t0 + 2);
        check("full_busy_cycles", busy_cnt, 2);
        check("full_status_busy", 32'(first_status), 32'h01);
        check("full_end_cycle", cyc, t0 + 3);
        port_read(BASE + 16'd7, rd); check("full_status_done", 32'(rd), 32'h02);

        // odd edges, read-modify-write of both nibble positions
        ram[0] = 8'h12;
        ram[1] = 8'h34;
        set_rect(1, 0, 2, 1, 8'h0A);
        start_fill();
        wait_fill();
        check("odd_count", wr_add.size(), 2);
        check_wr("odd_w0", 0, 0, 32'h1A, t0 + 3);
        check_wr("odd_w1", 1, 1, 32'hA4, t0 + 6);
        check("odd_busy_cycles", busy_cnt, 6);
        check("odd_ram0", 32'(ram[0]), 32'h1A);
        check("odd_ram1", 32'(ram[1]), 32'hA4);

        // clipping at the bottom-right corner
        set_rect(318, 199, 10, 10, 8'h0F);
        start_fill();
        wait_fill();
        check("clip_count", wr_add.size(), 1);
        check_wr("clip_w0", 0, 31999, 32'hFF, t0 + 1);
        check("clip_addr_range", addr_bad, 0);
        check("clip_busy_cycles", busy_cnt, 1);

        // degenerate: zero width, then X off-screen
        set_rect(0, 0, 0, 1, 8'h03);
        start_fill();
        wait_fill();
        check("deg_w0_count", wr_add.size(), 0);
        check("deg_w0_busy", busy_cnt, 0);
        check("deg_w0_status", 32'(first_status), 32'h02);
        set_rect(400, 0, 4, 1, 8'h03);
        start_fill();
        wait_fill();
        check("deg_x_count", wr_add.size(), 0);
        check("deg_x_busy", busy_cnt, 0);
        check("deg_x_status", 32'(first_status), 32'h02);

        // multi-row, no gap between rows
        set_rect(2, 10, 2, 3, 8'h07);
        start_fill();
        wait_fill();
        check("rows_count", wr_add.size(), 3);
        check_wr("rows_w0", 0, 1601, 32'h77, t0 + 1);
        check_wr("rows_w1", 1, 1761, 32'h77, t0 + 2);
        check_wr("rows_w2", 2, 1921, 32'h77, t0 + 3);
        check("rows_busy_cycles", busy_cnt, 3);

        // COLOR write and START while busy are ignored
        set_rect(0, 0, 320, 2, 8'h03);
        start_fill();
        port_write(3'd6, 8'h0C);
        port_write(3'd7, 8'h00);
        wait_fill();
        check("intf_count", wr_add.size(), 320);
        nd = 0;
        foreach (wr_dat[i]) if (wr_dat[i] != 32'h33) nd++;
        check("intf_bad_data", nd, 0);
        check_wr("intf_last", 319, 319, 32'h33, t0 + 320);
        port_read(BASE + 16'd6, rd); check("intf_color_kept", 32'(rd), 32'h03);

        // reset mid-fill
        set_rect(0, 0, 320, 2, 8'h03);
        start_fill();
        repeat (10) @(negedge clk);
        check("rstmid_was_busy", 32'(busy), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wr_add.delete();
        wr_dat.delete();
        wr_cyc.delete();
        busy_cnt = 0;
        repeat (20) @(negedge clk);
        check("rstmid_writes", wr_add.size(), 0);
        check("rstmid_busy_cycles", busy_cnt, 0);
        port_read(BASE + 16'd7, rd); check("rstmid_status", 32'(rd), 0);
        port_read(BASE + 16'd6, rd); check("rstmid_color", 32'(rd), 0);
        port_read(BASE + 16'd3, rd); check("rstmid_w", 32'(rd), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
